rggen_axi4lite_front_end: RTL

AXI4-Lite slave front end that converts AXI4-Lite channel traffic into the single-request register bus consumed by the common register adapter. It sits directly upstream of that adapter:
- Buffers the AW, W and AR channels independently and arbitrates between reads and writes.
- Holds exactly one bus request stable until the adapter returns ready.
- Returns the captured status and read data on the B or R channel.

---
 rtl/rggen_axi4lite_front_end_pkg.sv | 23 ++
 rtl/rggen_hold_slot.sv | 55 +++++
 rtl/rggen_axi4lite_front_end.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/rggen_axi4lite_front_end_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rggen_axi4lite_front_end_pkg
//  Description : Shared rggen register-bus access/status codes and helpers
//                used by the AXI4-Lite front end.
//  Revision    : 1.0 - initial release
// ============================================================================
package rggen_axi4lite_front_end_pkg;

    // Register-bus access codes
    localparam logic [1:0] RGGEN_READ        = 2'b10;
    localparam logic [1:0] RGGEN_WRITE       = 2'b11;

    // Register-bus status codes (numerically identical to AXI OKAY/SLVERR)
    localparam logic [1:0] RGGEN_OKAY        = 2'b00;
    localparam logic [1:0] RGGEN_SLAVE_ERROR = 2'b10;

    function automatic logic [1:0] rggen_access_code(input logic is_write);
        return is_write ? RGGEN_WRITE : RGGEN_READ;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rggen_hold_slot.sv
`default_nettype none
// ============================================================================
//  Module      : rggen_hold_slot
//  Description : One-entry valid/ready holding register. Loads on its own
//                handshake, holds until i_release, and presents a registered
//                ready that equals "slot empty in the coming cycle".
//  Ports       : i_clk, i_rst            - clock, async active-high reset
//                i_valid/o_ready/i_data  - upstream handshake and payload
//                i_release               - frees the slot at this edge
//                o_full/o_data           - held entry
//  Revision    : 1.0 - initial release
// ============================================================================
module rggen_hold_slot #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_release,
    output logic             o_full,
    output logic [WIDTH-1:0] o_data
);

    logic             r_full;
    logic             r_ready;
    logic [WIDTH-1:0] r_data;
    logic             w_load;
    logic             w_full_next;

    // r_ready mirrors !r_full, so load and release never coincide.
    assign w_load      = i_valid && r_ready;
    assign w_full_next = w_load || (r_full && !i_release);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_full  <= 1'b0;
            r_ready <= 1'b0;
            r_data  <= '0;
        end else begin
            r_full  <= w_full_next;
            r_ready <= !w_full_next;
            if (w_load) begin
                r_data <= i_data;
            end
        end
    end

    assign o_ready = r_ready;
    assign o_full  = r_full;
    assign o_data  = r_data;

endmodule
`default_nettype wire

// File: rtl/rggen_axi4lite_front_end.sv
`default_nettype none
// ============================================================================
//  Module      : rggen_axi4lite_front_end
//  Description : AXI4-Lite slave front end feeding the rggen register bus.
//                AW, W and AR are buffered independently; a three-state FSM
//                (IDLE, BUS_ACCESS, RESPONSE) arbitrates, issues one bus
//                request at a time and returns the result on B or R.
//  Ports       : i_clk, i_rst                - clock, async active-high reset
//                AXI AW/W/B/AR/R channels    - slave side
//                o_bus_* / i_bus_*           - register bus to the adapter
//  Revision    : 1.0 - initial release
// ============================================================================
module rggen_axi4lite_front_end
    import rggen_axi4lite_front_end_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 8,
    parameter int BUS_WIDTH     = 32,
    parameter int STROBE_WIDTH  = BUS_WIDTH / 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_awvalid,
    output logic                     o_awready,
    input  logic [ADDRESS_WIDTH-1:0] i_awaddr,
    input  logic                     i_wvalid,
    output logic                     o_wready,
    input  logic [BUS_WIDTH-1:0]     i_wdata,
    input  logic [STROBE_WIDTH-1:0]  i_wstrb,
    output logic                     o_bvalid,
    input  logic                     i_bready,
    output logic [1:0]               o_bresp,
    input  logic                     i_arvalid,
    output logic                     o_arready,
    input  logic [ADDRESS_WIDTH-1:0] i_araddr,
    output logic                     o_rvalid,
    input  logic                     i_rready,
    output logic [BUS_WIDTH-1:0]     o_rdata,
    output logic [1:0]               o_rresp,
    output logic                     o_bus_valid,
    output logic [1:0]               o_bus_access,
    output logic [ADDRESS_WIDTH-1:0] o_bus_address,
    output logic [BUS_WIDTH-1:0]     o_bus_write_data,
    output logic [STROBE_WIDTH-1:0]  o_bus_strobe,
    input  logic                     i_bus_ready,
    input  logic [1:0]               i_bus_status,
    input  logic [BUS_WIDTH-1:0]     i_bus_read_data
);

    localparam logic [1:0] c_STATE_IDLE       = 2'd0;
    localparam logic [1:0] c_STATE_BUS_ACCESS = 2'd1;
    localparam logic [1:0] c_STATE_RESPONSE   = 2'd2;
    localparam int         c_W_WIDTH          = BUS_WIDTH + STROBE_WIDTH;

    logic [1:0]               r_state;
    logic                     r_select_write;
    logic                     r_last_write;     // 0 = read served last
    logic [1:0]               r_bresp;
    logic [1:0]               r_rresp;
    logic [BUS_WIDTH-1:0]     r_rdata;

    logic                     w_aw_full;
    logic                     w_w_full;
    logic                     w_ar_full;
    logic [ADDRESS_WIDTH-1:0] w_aw_addr;
    logic [ADDRESS_WIDTH-1:0] w_ar_addr;
    logic [c_W_WIDTH-1:0]     w_w_payload;
    logic                     w_write_pending;
    logic                     w_read_pending;
    logic                     w_pick_write;
    logic                     w_bus_valid;
    logic                     w_bus_done;
    logic                     w_resp_done;

    // ------------------------------------------------------------------
    // Channel buffers
    // ------------------------------------------------------------------
    rggen_hold_slot #(.WIDTH(ADDRESS_WIDTH)) u_aw_slot (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_valid   (i_awvalid),
        .o_ready   (o_awready),
        .i_data    (i_awaddr),
        .i_release (w_bus_done && r_select_write),
        .o_full    (w_aw_full),
        .o_data    (w_aw_addr)
    );

    rggen_hold_slot #(.WIDTH(c_W_WIDTH)) u_w_slot (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_valid   (i_wvalid),
        .o_ready   (o_wready),
        .i_data    ({i_wstrb, i_wdata}),
        .i_release (w_bus_done && r_select_write),
        .o_full    (w_w_full),
        .o_data    (w_w_payload)
    );

    rggen_hold_slot #(.WIDTH(ADDRESS_WIDTH)) u_ar_slot (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_valid   (i_arvalid),
        .o_ready   (o_arready),
        .i_data    (i_araddr),
        .i_release (w_bus_done && !r_select_write),
        .o_full    (w_ar_full),
        .o_data    (w_ar_addr)
    );

    // ------------------------------------------------------------------
    // Arbitration and control
    // ------------------------------------------------------------------
    assign w_write_pending = w_aw_full && w_w_full;
    assign w_read_pending  = w_ar_full;
    // On contention serve the kind that was not served last.
    assign w_pick_write    = w_write_pending && (!w_read_pending || !r_last_write);
    assign w_bus_valid     = (r_state == c_STATE_BUS_ACCESS);
    assign w_bus_done      = w_bus_valid && i_bus_ready;
    assign w_resp_done     = (o_bvalid && i_bready) || (o_rvalid && i_rready);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state        <= c_STATE_IDLE;
            r_select_write <= 1'b0;
            r_last_write   <= 1'b0;
            r_bresp        <= 2'b00;
            r_rresp        <= 2'b00;
            r_rdata        <= '0;
        end else begin
            case (r_state)
                c_STATE_IDLE: begin
                    if (w_write_pending || w_read_pending) begin
                        r_select_write <= w_pick_write;
                        r_state        <= c_STATE_BUS_ACCESS;
                    end
                end
                c_STATE_BUS_ACCESS: begin
                    if (i_bus_ready) begin
                        r_last_write <= r_select_write;
                        if (r_select_write) begin
                            r_bresp <= i_bus_status;
                        end else begin
                            r_rresp <= i_bus_status;
                            r_rdata <= i_bus_read_data;
                        end
                        r_state <= c_STATE_RESPONSE;
                    end
                end
                c_STATE_RESPONSE: begin
                    if (w_resp_done) begin
                        r_state <= c_STATE_IDLE;
                    end
                end
                default: begin
                    r_state <= c_STATE_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs: bus fields are zero whenever no request is presented.
    // ------------------------------------------------------------------
    assign o_bus_valid      = w_bus_valid;
    assign o_bus_access     = w_bus_valid ? rggen_access_code(r_select_write) : 2'b00;
    assign o_bus_address    = !w_bus_valid  ? '0
                            : r_select_write ? w_aw_addr : w_ar_addr;
    assign o_bus_write_data = (w_bus_valid && r_select_write) ? w_w_payload[BUS_WIDTH-1:0] : '0;
    assign o_bus_strobe     = !w_bus_valid  ? '0
                            : r_select_write ? w_w_payload[BUS_WIDTH +: STROBE_WIDTH] : '1;

    assign o_bvalid = (r_state == c_STATE_RESPONSE) &&  r_select_write;
    assign o_rvalid = (r_state == c_STATE_RESPONSE) && !r_select_write;
    assign o_bresp  = r_bresp;
    assign o_rresp  = r_rresp;
    assign o_rdata  = r_rdata;

endmodule
`default_nettype wire
